// File: rtl/fc_pkg.sv
// Shared constants, address widths and FSM encoding for the FC layer scheduler.
package fc_pkg;

    localparam int INPUT_NUM  = 48;
    localparam int OUTPUT_NUM = 10;
    localparam int LANE_DEPTH = 16;

    localparam int W_ADDR_W  = 9;
    localparam int X_ADDR_W  = 6;
    localparam int BEAT_W    = 4;
    localparam int OUT_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_MAC,
        ST_DRAIN,
        ST_OUT
    } fc_state_e;

    // Row-major weight layout: one row of in_num weights per output class.
    function automatic logic [W_ADDR_W-1:0] weight_addr(
        input logic [OUT_IDX_W-1:0] oi,
        input logic [X_ADDR_W-1:0]  k,
        input logic [W_ADDR_W-1:0]  in_num
    );
        logic [W_ADDR_W-1:0] base;
        base = W_ADDR_W'(oi) * in_num;
        return base + W_ADDR_W'(k);
    endfunction

endpackage

// File: rtl/fc_addr_gen.sv
// Input-index counter k and weight/buffer address generation for one output row.
module fc_addr_gen #(
    parameter int INPUT_NUM = fc_pkg::INPUT_NUM
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           step_i,
    input  logic [fc_pkg::OUT_IDX_W-1:0]   out_idx_i,
    output logic                           k_first_o,
    output logic                           k_last_o,
    output logic [fc_pkg::W_ADDR_W-1:0]    w_addr_o,
    output logic [fc_pkg::X_ADDR_W-1:0]    x_addr_o
);
    import fc_pkg::*;

    localparam logic [W_ADDR_W-1:0] IN_NUM_W = W_ADDR_W'(INPUT_NUM);
    localparam logic [X_ADDR_W-1:0] K_LAST   = X_ADDR_W'(INPUT_NUM - 1);

    logic [X_ADDR_W-1:0] k_q;
    logic [X_ADDR_W-1:0] k_d;

    assign k_first_o = (k_q == '0);
    assign k_last_o  = (k_q == K_LAST);

    // k wraps on its own after the last input, so every row starts at 0.
    always_comb begin
        k_d = k_q;
        if (step_i) begin
            k_d = k_last_o ? '0 : k_q + X_ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    assign w_addr_o = step_i ? weight_addr(out_idx_i, k_q, IN_NUM_W) : '0;
    assign x_addr_o = step_i ? k_q : '0;

endmodule

// File: rtl/fc_scheduler.sv
// Frame scheduler for a fully-connected layer: buffer fill, per-class MAC sweep,
// pipeline drain and handshaked result output.
module fc_scheduler #(
    parameter int INPUT_NUM  = fc_pkg::INPUT_NUM,
    parameter int OUTPUT_NUM = fc_pkg::OUTPUT_NUM,
    parameter int LANE_DEPTH = fc_pkg::LANE_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_in,
    output logic                           in_ready,
    output logic                           buf_wr_en,
    output logic [fc_pkg::BEAT_W-1:0]      buf_wr_idx,
    output logic                           rd_en,
    output logic [fc_pkg::W_ADDR_W-1:0]    w_addr,
    output logic [fc_pkg::X_ADDR_W-1:0]    x_addr,
    output logic                           mac_en,
    output logic                           mac_first,
    output logic [fc_pkg::OUT_IDX_W-1:0]   out_idx,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           frame_done,
    output logic                           overrun
);
    import fc_pkg::*;

    localparam logic [BEAT_W-1:0]    BEAT_LAST = BEAT_W'(LANE_DEPTH - 1);
    localparam logic [OUT_IDX_W-1:0] OUT_LAST  = OUT_IDX_W'(OUTPUT_NUM - 1);

    fc_state_e             state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [OUT_IDX_W-1:0]  out_idx_q, out_idx_d;
    logic                  drain_q, drain_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_done_q, frame_done_d;
    logic                  mac_en_q;
    logic                  mac_first_q;
    logic                  k_first;
    logic                  k_last;

    fc_addr_gen #(
        .INPUT_NUM (INPUT_NUM)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .step_i    (rd_en),
        .out_idx_i (out_idx_q),
        .k_first_o (k_first),
        .k_last_o  (k_last),
        .w_addr_o  (w_addr),
        .x_addr_o  (x_addr)
    );

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        out_idx_d    = out_idx_q;
        drain_d      = drain_q;
        frame_done_d = 1'b0;
        in_ready     = 1'b0;
        buf_wr_en    = 1'b0;
        buf_wr_idx   = '0;
        rd_en        = 1'b0;
        out_valid    = 1'b0;
        overrun_d    = overrun_q | (valid_in & (state_q != ST_FILL));

        unique case (state_q)
            ST_FILL: begin
                in_ready = 1'b1;
                if (valid_in) begin
                    buf_wr_en  = 1'b1;
                    buf_wr_idx = beat_q;
                    if (beat_q == BEAT_LAST) begin
                        beat_d  = '0;
                        state_d = ST_MAC;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_MAC: begin
                rd_en = 1'b1;
                if (k_last) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end
            end
            // Two cycles: memory read latency, then the final accumulate.
            ST_DRAIN: begin
                if (drain_q) begin
                    state_d = ST_OUT;
                    drain_d = 1'b0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (out_idx_q == OUT_LAST) begin
                        out_idx_d    = '0;
                        frame_done_d = 1'b1;
                        state_d      = ST_FILL;
                    end else begin
                        out_idx_d = out_idx_q + OUT_IDX_W'(1);
                        state_d   = ST_MAC;
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FILL;
            beat_q       <= '0;
            out_idx_q    <= '0;
            drain_q      <= 1'b0;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
            mac_en_q     <= 1'b0;
            mac_first_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            out_idx_q    <= out_idx_d;
            drain_q      <= drain_d;
            overrun_q    <= overrun_d;
            frame_done_q <= frame_done_d;
            mac_en_q     <= rd_en;
            mac_first_q  <= rd_en & k_first;
        end
    end

    assign mac_en     = mac_en_q;
    assign mac_first  = mac_first_q;
    assign out_idx    = out_idx_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/fc_scheduler.md
FC_SCHEDULER -- requirements
Module: fc_scheduler

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with ports clk and rst; all state changes on posedge clk.
REQ-002 Parameter INPUT_NUM, 48, FC inputs per frame.
REQ-003 Parameter OUTPUT_NUM, 10, FC outputs per frame.
REQ-004 Parameter LANE_DEPTH, 16, beats per frame (3 lanes per beat).
REQ-005 Port clk  in  1  clock.
REQ-006 Port rst  in  1  synchronous active-high reset.
REQ-007 Port valid_in  in  1  upstream beat strobe (3 lane values present).
REQ-008 Port in_ready  out  1  high while beats are accepted (FILL).
REQ-009 Port buf_wr_en  out  1  input-buffer write strobe (writes idx, idx+16, idx+32).
REQ-010 Port buf_wr_idx  out  4  beat index 0..15.
REQ-011 Port rd_en  out  1  weight/buffer read strobe.
REQ-012 Port w_addr  out  9  weight address, out_idx*48+k, range 0..479.
REQ-013 Port x_addr  out  6  buffer address k, range 0..47.
REQ-014 Port mac_en  out  1  accumulate strobe.
REQ-015 Port mac_first  out  1  accumulator loads product+bias[out_idx] instead of adding.
REQ-016 Port out_idx  out  4  current output (class) index 0..9.
REQ-017 Port out_valid  out  1  accumulator result for out_idx is final.
REQ-018 Port out_ready  in  1  downstream accepts result.
REQ-019 Port frame_done  out  1  one-cycle pulse after output 9 accepted.
REQ-020 Port overrun  out  1  sticky: valid_in seen while in_ready low.

Function
REQ-021 States SHALL be FILL, MAC, DRAIN, OUT; reset state FILL.
REQ-022 FILL: in_ready=1; each valid_in SHALL assert buf_wr_en same cycle with buf_wr_idx=beat count, then increment count.
REQ-023 On beat 15 accepted, count SHALL wrap to 0 and state SHALL go to MAC next cycle.
REQ-024 MAC: for k=0..47 on consecutive cycles, rd_en=1, x_addr=k, w_addr=out_idx*48+k; after k=47, go to DRAIN.
REQ-025 mac_en SHALL equal rd_en delayed one cycle; mac_first SHALL equal (rd_en && k==0) delayed one cycle.
REQ-026 DRAIN SHALL last exactly 2 cycles (read + accumulate latency), then OUT.
REQ-027 OUT: out_valid=1, out_idx stable until out_valid&&out_ready; out_ready low stalls indefinitely.
REQ-028 On accept with out_idx<9: out_idx+1, state MAC next cycle; with out_idx==9: out_idx=0, frame_done=1 for one cycle, state FILL.
REQ-029 Per-output period SHALL be 51 cycles with out_ready held high (48 MAC + 2 DRAIN + 1 OUT); first out_valid 51 cycles after MAC entry.
REQ-030 valid_in outside FILL SHALL be ignored (no buf_wr_en, no count change) and SHALL set overrun.
REQ-031 w_addr arithmetic SHALL use 9-bit unsigned product/sum, no truncation for defaults.
REQ-032 rd_en, mac_en, buf_wr_en, out_valid SHALL never be high in states other than specified.

Reset
REQ-033 rst SHALL force state FILL, beat count 0, k 0, out_idx 0, overrun 0, delay registers 0.
REQ-034 All outputs SHALL be 0 during/after reset except in_ready=1; reset mid-MAC or mid-OUT SHALL abandon the frame with no out_valid or frame_done.

Structure
REQ-035 Package fc_pkg SHALL hold INPUT_NUM, OUTPUT_NUM, LANE_DEPTH, address widths and the state enumeration.
REQ-036 One sub-module fc_addr_gen SHALL hold the k counter and w_addr/x_addr generation; FSM stays in fc_scheduler.

Verification
REQ-037 16 valid_in beats back-to-back -> buf_wr_idx 0..15, in_ready drops cycle after beat 15, rd_en rises next cycle.
REQ-038 One frame, out_ready=1 -> 10 out_valid pulses 51 cycles apart, out_idx 0..9, w_addr for output 3 spans 144..191, frame_done once.
REQ-039 out_ready low 20 cycles at out_idx=4 -> out_valid held 20 cycles, out_idx=4 stable, no rd_en, resumes with w_addr=240.
REQ-040 valid_in during MAC -> no buf_wr_en, overrun=1 and stays 1 until rst.
REQ-041 rst asserted at k=30 of out_idx=2 -> next cycle state FILL, out_idx=0, in_ready=1, no out_valid.
REQ-042 Every mac_en cycle -> w_addr/x_addr of previous cycle match k; mac_first exactly 10 times per frame.
